// File: rtl/bitcoin_result_checker_if.sv
// rtl/bitcoin_result_checker_if.sv - run control, hash input and result FIFO signals of the result checker
interface bitcoin_result_checker_if;
  logic         start;
  logic         abort;
  logic [31:0]  blk_nbits;
  logic         stop_on_find;
  logic [255:0] bitcoin_blk;
  logic [31:0]  bitcoin_nonce;
  logic         bitcoin_done;
  logic [31:0]  found_nonce;
  logic         found_valid;
  logic         found_ready;
  logic         busy;
  logic         halted;
  logic         overflow;
  logic [31:0]  hash_count;

  modport master (
    output start, abort, blk_nbits, stop_on_find, bitcoin_blk, bitcoin_nonce, bitcoin_done, found_ready,
    input  found_nonce, found_valid, busy, halted, overflow, hash_count
  );

  modport slave (
    input  start, abort, blk_nbits, stop_on_find, bitcoin_blk, bitcoin_nonce, bitcoin_done, found_ready,
    output found_nonce, found_valid, busy, halted, overflow, hash_count
  );
endinterface

// File: rtl/bitcoin_result_checker.sv
// rtl/bitcoin_result_checker.sv - compact-target hash checker with a 4-deep nonce result FIFO
// Optional BTC_HASH_BYTE_REVERSE_EN: byte-reverse bitcoin_blk at stage 1 before comparison.
module bitcoin_result_checker (
  input  logic                    clk,
  input  logic                    reset,
  bitcoin_result_checker_if.slave bus
);
  typedef enum logic [1:0] {IDLE, LOAD, RUN, HALT} state_t;
  state_t state_q, state_d;

  logic [31:0]  nbits_q;
  logic         stop_q;
  logic [255:0] target_q, target_d;
  logic [7:0]   exp_b, shl, shr;
  logic [23:0]  man;
  logic [255:0] hash_in, s1_hash;
  logic         s1_valid, s2_valid, s2_match;
  logic [31:0]  s1_nonce, s2_nonce, count_q;
  logic [31:0]  fifo_mem [4];
  logic [1:0]   rd_ptr, wr_ptr;
  logic [2:0]   fifo_cnt;
  logic         overflow_q;
  logic         start_ok, clear_all, accept, push_req, push, pop, fifo_full;

  assign start_ok  = bus.start && !bus.abort && (state_q == IDLE || state_q == HALT);
  assign clear_all = start_ok && (state_q == IDLE);
  assign accept    = bus.bitcoin_done && !bus.abort && (state_q == RUN);
  assign fifo_full = (fifo_cnt == 3'd4);
  assign pop       = (fifo_cnt != 3'd0) && bus.found_ready;
  assign push_req  = s2_valid && s2_match && !bus.abort;
  // A pop in the same cycle frees the slot a full FIFO would otherwise refuse.
  assign push      = push_req && (!fifo_full || pop);

  always_comb begin
    exp_b    = nbits_q[31:24];
    man      = nbits_q[23:0];
    shl      = (exp_b - 8'd3) << 3;
    shr      = (8'd3 - exp_b) << 3;
    target_d = '0;
    if (man[23])
      target_d = '0;
    else if (exp_b > 8'd32)
      target_d = '1;
    else if (exp_b >= 8'd3)
      target_d = {232'd0, man} << shl;
    else
      target_d = {232'd0, man} >> shr;
  end

  always_comb begin
`ifdef BTC_HASH_BYTE_REVERSE_EN
    hash_in = '0;
    for (int i = 0; i < 32; i++)
      hash_in[8*i +: 8] = bus.bitcoin_blk[8*(31-i) +: 8];
`else
    hash_in = bus.bitcoin_blk;
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (bus.abort)
      state_d = IDLE;
    else begin
      case (state_q)
        IDLE:    if (bus.start) state_d = LOAD;
        LOAD:    state_d = RUN;
        RUN:     if (push_req && stop_q) state_d = HALT;
        HALT:    if (bus.start) state_d = LOAD;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      nbits_q  <= '0;
      stop_q   <= 1'b0;
      target_q <= '0;
    end else begin
      if (start_ok) begin
        nbits_q <= bus.blk_nbits;
        stop_q  <= bus.stop_on_find;
      end
      if (state_q == LOAD) target_q <= target_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s2_match <= 1'b0;
      s1_hash  <= '0;
      s1_nonce <= '0;
      s2_nonce <= '0;
    end else begin
      s1_valid <= accept;
      s2_valid <= s1_valid && !bus.abort;
      if (accept) begin
        s1_hash  <= hash_in;
        s1_nonce <= bus.bitcoin_nonce;
      end
      if (s1_valid) begin
        s2_match <= (s1_hash <= target_q);
        s2_nonce <= s1_nonce;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                      count_q <= '0;
    else if (start_ok)               count_q <= '0;
    else if (s1_valid && !bus.abort) count_q <= count_q + 32'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_cnt   <= '0;
      overflow_q <= 1'b0;
      for (int i = 0; i < 4; i++) fifo_mem[i] <= '0;
    end else if (clear_all) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_cnt   <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= s2_nonce;
        wr_ptr           <= wr_ptr + 2'd1;
      end
      if (pop) rd_ptr <= rd_ptr + 2'd1;
      fifo_cnt <= fifo_cnt + {2'b00, push} - {2'b00, pop};
      if (push_req && !push) overflow_q <= 1'b1;
    end
  end

  assign bus.found_valid = (fifo_cnt != 3'd0);
  assign bus.found_nonce = bus.found_valid ? fifo_mem[rd_ptr] : 32'd0;
  assign bus.busy        = (state_q != IDLE);
  assign bus.halted      = (state_q == HALT);
  assign bus.overflow    = overflow_q;
  assign bus.hash_count  = count_q;
endmodule

// File: tb/tb_bitcoin_result_checker.sv
// tb/tb_bitcoin_result_checker.sv - self-checking bench for bitcoin_result_checker
module tb_bitcoin_result_checker;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  bitcoin_result_checker_if bus();
  bitcoin_result_checker dut (.clk(clk), .reset(reset), .bus(bus));

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [31:0]  nbits;
    logic [255:0] hash;
    logic [31:0]  nonce;
    logic         match;
  } vec_t;
  vec_t vt[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  function automatic logic [255:0] as_presented(input logic [255:0] h);
    logic [255:0] r;
`ifdef BTC_HASH_BYTE_REVERSE_EN
    for (int i = 0; i < 32; i++) r[8*i +: 8] = h[8*(31-i) +: 8];
`else
    r = h;
`endif
    return r;
  endfunction

  // Target straight from the compact-encoding arithmetic: mantissa times/divided by a power of 256.
  function automatic logic [255:0] model_target(input logic [31:0] nbits);
    int e;
    logic [255:0] m;
    e = int'(nbits[31:24]);
    m = 256'(nbits[22:0]);
    if (nbits[23]) return '0;
    if (e > 32) return '1;
    if (e >= 3) return m * (256'd2 ** (8 * (e - 3)));
    return m / (256'd2 ** (8 * (3 - e)));
  endfunction

  task automatic cyc(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_abort();
    bus.abort = 1'b1;
    cyc();
    bus.abort = 1'b0;
  endtask

  task automatic begin_run(input logic [31:0] nbits, input logic stop);
    bus.blk_nbits    = nbits;
    bus.stop_on_find = stop;
    bus.start        = 1'b1;
    cyc();
    bus.start        = 1'b0;
    cyc();
  endtask

  task automatic send_hash(input logic [255:0] h, input logic [31:0] nonce);
    bus.bitcoin_blk   = as_presented(h);
    bus.bitcoin_nonce = nonce;
    bus.bitcoin_done  = 1'b1;
    cyc();
    bus.bitcoin_done  = 1'b0;
  endtask

  task automatic pop_expect(input string name, input logic [31:0] nonce);
    chk1({name, "_valid"}, bus.found_valid, 1'b1);
    chk({name, "_nonce"}, bus.found_nonce, nonce);
    bus.found_ready = 1'b1;
    cyc();
    bus.found_ready = 1'b0;
  endtask

  initial begin
    logic [255:0] tgt, h;
    logic [31:0]  nbits, nonce;
    logic [31:0]  expq[$];
    logic         exp_ovf;
    int           k, e;

    vt[0]  = '{32'h1d00ffff, 256'hFFFF << 208, 32'h12345678, 1'b1};
    vt[1]  = '{32'h1d00ffff, {256{1'b1}}, 32'h00000001, 1'b0};
    vt[2]  = '{32'h1d00ffff, (256'hFFFF << 208) + 256'd1, 32'h00000002, 1'b0};
    vt[3]  = '{32'h1d00ffff, 256'd0, 32'h00000003, 1'b1};
    vt[4]  = '{32'h01800000, 256'd0, 32'h00000004, 1'b1};
    vt[5]  = '{32'h01800000, 256'd1, 32'h00000005, 1'b0};
    vt[6]  = '{32'h21010000, {256{1'b1}}, 32'hCAFEF00D, 1'b1};
    vt[7]  = '{32'h03123456, 256'h123456, 32'h00000007, 1'b1};
    vt[8]  = '{32'h03123456, 256'h123457, 32'h00000008, 1'b0};
    vt[9]  = '{32'h02123456, 256'h1234, 32'h00000009, 1'b1};
    vt[10] = '{32'h02123456, 256'h1235, 32'h0000000A, 1'b0};
    vt[11] = '{32'h20000001, 256'd1 << 232, 32'h0000000B, 1'b1};
    vt[12] = '{32'h20000001, (256'd1 << 232) + 256'd1, 32'h0000000C, 1'b0};

    reset = 1'b0;
    bus.start = 1'b0; bus.abort = 1'b0; bus.blk_nbits = '0; bus.stop_on_find = 1'b0;
    bus.bitcoin_blk = '0; bus.bitcoin_nonce = '0; bus.bitcoin_done = 1'b0; bus.found_ready = 1'b0;
    cyc(2);
    chk1("rst_found_valid", bus.found_valid, 1'b0);
    chk("rst_found_nonce", bus.found_nonce, 32'd0);
    chk1("rst_busy", bus.busy, 1'b0);
    chk1("rst_halted", bus.halted, 1'b0);
    chk1("rst_overflow", bus.overflow, 1'b0);
    chk("rst_hash_count", bus.hash_count, 32'd0);
    reset = 1'b1;
    cyc();

    for (int i = 0; i < 13; i++) begin
      pulse_abort();
      begin_run(vt[i].nbits, 1'b0);
      chk1($sformatf("vec%0d_busy", i), bus.busy, 1'b1);
      send_hash(vt[i].hash, vt[i].nonce);
      cyc();
      chk1($sformatf("vec%0d_early_valid", i), bus.found_valid, 1'b0);
      chk($sformatf("vec%0d_hash_count", i), bus.hash_count, 32'd1);
      cyc();
      chk1($sformatf("vec%0d_found_valid", i), bus.found_valid, vt[i].match);
      chk($sformatf("vec%0d_found_nonce", i), bus.found_nonce, vt[i].match ? vt[i].nonce : 32'd0);
      if (vt[i].match) begin
        bus.found_ready = 1'b1;
        cyc();
        bus.found_ready = 1'b0;
        chk1($sformatf("vec%0d_drained", i), bus.found_valid, 1'b0);
      end
    end

    // stop_on_find: halt after first write, later pipeline matches still land, 4th hash ignored
    pulse_abort();
    begin_run(32'h21010000, 1'b1);
    for (int i = 1; i <= 4; i++) send_hash(256'd0, 32'(i));
    cyc(3);
    chk1("halt_halted", bus.halted, 1'b1);
    chk1("halt_busy", bus.busy, 1'b1);
    chk("halt_hash_count", bus.hash_count, 32'd3);
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    chk("halt_restart_count", bus.hash_count, 32'd0);
    chk1("halt_restart_halted", bus.halted, 1'b0);
    for (int i = 1; i <= 3; i++) pop_expect($sformatf("halt_pop%0d", i), 32'(i));
    chk1("halt_empty", bus.found_valid, 1'b0);

    // overflow: six matches into a 4-deep FIFO with no consumer
    pulse_abort();
    begin_run(32'h21010000, 1'b0);
    for (int i = 0; i < 6; i++) send_hash(256'd5, 32'hA0 + 32'(i));
    cyc(3);
    chk1("ovf_flag", bus.overflow, 1'b1);
    chk("ovf_hash_count", bus.hash_count, 32'd6);
    for (int i = 0; i < 4; i++) pop_expect($sformatf("ovf_pop%0d", i), 32'hA0 + 32'(i));
    chk1("ovf_empty", bus.found_valid, 1'b0);
    pulse_abort();
    chk1("ovf_sticky", bus.overflow, 1'b1);
    begin_run(32'h21010000, 1'b0);
    chk1("ovf_cleared", bus.overflow, 1'b0);

    // push into a full FIFO with a pop in the same cycle succeeds
    pulse_abort();
    begin_run(32'h21010000, 1'b0);
    for (int i = 1; i <= 5; i++) send_hash(256'd0, 32'hB0 + 32'(i));
    cyc();
    bus.found_ready = 1'b1;
    cyc();
    bus.found_ready = 1'b0;
    chk1("fullpop_no_ovf", bus.overflow, 1'b0);
    for (int i = 2; i <= 5; i++) pop_expect($sformatf("fullpop_pop%0d", i), 32'hB0 + 32'(i));

    // consumer ready while empty: the write still shows for one cycle
    pulse_abort();
    begin_run(32'h21010000, 1'b0);
    bus.found_ready = 1'b1;
    send_hash(256'd0, 32'h55);
    cyc();
    chk1("emptypop_early", bus.found_valid, 1'b0);
    cyc();
    chk1("emptypop_valid", bus.found_valid, 1'b1);
    chk("emptypop_nonce", bus.found_nonce, 32'h55);
    cyc();
    chk1("emptypop_popped", bus.found_valid, 1'b0);
    bus.found_ready = 1'b0;

    // abort with a match in flight: flushed, nothing written
    pulse_abort();
    begin_run(32'h21010000, 1'b0);
    send_hash(256'd0, 32'h77);
    pulse_abort();
    cyc(3);
    chk1("abort_no_write", bus.found_valid, 1'b0);
    chk1("abort_busy", bus.busy, 1'b0);

    // randomized runs against the reference model
    for (int r = 0; r < 10; r++) begin
      e = $urandom_range(0, 34);
      nbits = {8'(e), 24'($urandom_range(0, 32'hFFFFFF))};
      if ($urandom_range(0, 7) != 0) nbits[23] = 1'b0;
      tgt = model_target(nbits);
      expq.delete();
      exp_ovf = 1'b0;
      pulse_abort();
      begin_run(nbits, 1'b0);
      k = $urandom_range(1, 7);
      for (int i = 0; i < k; i++) begin
        if ($urandom_range(0, 2) == 0)
          h = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom} >> $urandom_range(0, 255);
        else
          h = tgt + 256'($urandom_range(0, 6)) - 256'd3;
        nonce = $urandom;
        if (h <= tgt) begin
          if (expq.size() < 4) expq.push_back(nonce);
          else exp_ovf = 1'b1;
        end
        send_hash(h, nonce);
        cyc($urandom_range(0, 2));
      end
      cyc(4);
      chk($sformatf("rnd%0d_hash_count", r), bus.hash_count, 32'(k));
      chk1($sformatf("rnd%0d_overflow", r), bus.overflow, exp_ovf);
      while (expq.size() > 0) pop_expect($sformatf("rnd%0d_pop", r), expq.pop_front());
      chk1($sformatf("rnd%0d_empty", r), bus.found_valid, 1'b0);
    end

    // asynchronous reset with one result stored and another match in flight
    pulse_abort();
    begin_run(32'h21010000, 1'b0);
    send_hash(256'd0, 32'h0000D001);
    cyc();
    send_hash(256'd0, 32'h0000D002);
    chk1("arst_pre_valid", bus.found_valid, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    chk1("arst_found_valid", bus.found_valid, 1'b0);
    chk("arst_found_nonce", bus.found_nonce, 32'd0);
    chk1("arst_busy", bus.busy, 1'b0);
    chk1("arst_halted", bus.halted, 1'b0);
    chk1("arst_overflow", bus.overflow, 1'b0);
    chk("arst_hash_count", bus.hash_count, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    cyc(4);
    chk1("arst_after_valid", bus.found_valid, 1'b0);
    chk1("arst_after_busy", bus.busy, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/bitcoin_result_checker.md
BITCOIN_RESULT_CHECKER -- requirements
Module: bitcoin_result_checker

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: port clk (input, 1, rising-edge clock) and port reset (input, 1, asynchronous active-low reset).
REQ-002 start  input  1: single-cycle pulse that begins a run and samples blk_nbits and stop_on_find.
REQ-003 abort  input  1: single-cycle pulse that ends a run and returns to IDLE.
REQ-004 blk_nbits  input  32: compact target ({exponent[31:24], mantissa[23:0]}).
REQ-005 stop_on_find  input  1: when 1, the run halts after the first match.
REQ-006 bitcoin_blk  input  256: double-SHA256 header hash from the hashing pipeline.
REQ-007 bitcoin_nonce  input  32: nonce associated with bitcoin_blk.
REQ-008 bitcoin_done  input  1: qualifies bitcoin_blk and bitcoin_nonce for one cycle.
REQ-009 found_nonce  output  32: head entry of the result FIFO.
REQ-010 found_valid  output  1: the result FIFO is non-empty.
REQ-011 found_ready  input  1: consumer pops the FIFO head.
REQ-012 busy  output  1: high in LOAD, RUN and HALT.
REQ-013 halted  output  1: high in HALT.
REQ-014 overflow  output  1: sticky flag, set when a match is dropped.
REQ-015 hash_count  output  32: number of hashes checked in the current run.

Function
REQ-016 States SHALL be IDLE, LOAD, RUN and HALT.
- IDLE -> LOAD on start.
- LOAD -> RUN after exactly 1 cycle.
- RUN -> HALT on a match written while stop_on_find is sampled as 1.
- Any state -> IDLE on abort, which has priority over start.
- HALT -> LOAD on start.
REQ-017 In IDLE, start SHALL clear the FIFO, overflow and hash_count.
REQ-018 In HALT, start SHALL clear only hash_count.
REQ-019 LOAD SHALL register the target from the sampled nbits:
- exp = nbits[31:24], man = nbits[23:0].
- exp >= 3: target = man << 8*(exp-3).
- exp < 3: target = man >> 8*(3-exp).
- exp > 32: target = 2^256-1.
- man[23] = 1: target = 0.
REQ-020 bitcoin_done SHALL be accepted only in RUN; hashes arriving in any other state are ignored and not counted.
REQ-021 Pipeline:
- Stage 1 registers hash and nonce at the end of acceptance cycle N.
- Stage 2 registers the result of the unsigned 256-bit comparison hash <= target at the end of cycle N+1.
- The FIFO write occurs at the end of cycle N+2.
- found_valid is visible in cycle N+3 when the FIFO was empty.
REQ-022 hash_count SHALL increment at stage 2 for every accepted hash and wrap from 0xFFFFFFFF to 0.
REQ-023 Hashes already in the pipeline when HALT is entered SHALL still complete; further matches are written to the FIFO.
REQ-024 abort SHALL flush pipeline valid bits; the FIFO contents are kept.
REQ-025 The result FIFO SHALL be 4 entries of 32-bit nonces, first-word-fall-through, with a pop on found_valid && found_ready.
REQ-026 A match arriving while the FIFO is full with no pop in the same cycle SHALL be dropped and set overflow.
- If a pop occurs in the same cycle, the push succeeds.
REQ-027 A pop while the FIFO is empty SHALL be ignored.
- Simultaneous push and pop while empty leaves found_valid high in the following cycle.

Reset
REQ-028 While reset = 0, the block SHALL be in IDLE with the following values:
- FIFO empty.
- found_valid = 0, found_nonce = 0.
- busy = 0, halted = 0, overflow = 0.
- hash_count = 0.
- target = 0.
- Pipeline valid bits = 0.
REQ-029 Reset assertion mid-run SHALL take effect asynchronously, and no FIFO write occurs after assertion.

Configuration
REQ-030 With BTC_HASH_BYTE_REVERSE_EN defined, stage 1 SHALL reverse the byte order of bitcoin_blk before comparison (Bitcoin little-endian hash convention).
REQ-031 Without BTC_HASH_BYTE_REVERSE_EN, bitcoin_blk SHALL be compared as presented.

Verification
REQ-032 nbits = 0x1d00ffff, start, then one hash with bitcoin_blk = 0x00000000FFFF0000...0 (as compared) and nonce 0x12345678 -> found_valid in cycle N+3, found_nonce = 0x12345678, hash_count = 1.
REQ-033 nbits = 0x1d00ffff, hash = all-ones -> no FIFO write, hash_count increments, found_valid stays 0.
REQ-034 stop_on_find = 1, three back-to-back matches (nonces 1, 2, 3) -> halted = 1, FIFO holds 1, 2, 3, and a 4th hash arriving in HALT is ignored.
REQ-035 found_ready = 0, six matching hashes -> FIFO holds the first 4 nonces, overflow = 1, and the pops return them in order.
REQ-036 nbits = 0x01800000 (mantissa sign bit set) -> target = 0 and an all-zero hash is the only match; nbits = 0x21010000 -> target = 2^256-1 and every hash matches.
REQ-037 Drive reset low mid-pipeline with a match in flight -> all outputs are at reset values immediately, and found_valid stays 0 after reset deasserts.
